// File: rtl/muldiv_ctrl_if.sv
// rtl/muldiv_ctrl_if.sv - EX request, HI/LO result and multiplier-engine signals of the HI/LO unit
interface muldiv_ctrl_if;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        mul_en;
    logic        mul_cancel;
    logic [32:0] mul_a;
    logic [32:0] mul_b;
    logic [65:0] mul_res;
    logic        mul_working;
    logic        mul_finish;

    modport slave (
        input  req_valid, req_op, src_a, src_b, flush, mul_res, mul_working, mul_finish,
        output stall, hi, lo, mul_en, mul_cancel, mul_a, mul_b
    );

    modport master (
        output req_valid, req_op, src_a, src_b, flush, mul_res, mul_working, mul_finish,
        input  stall, hi, lo, mul_en, mul_cancel, mul_a, mul_b
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - HI/LO unit: multiplier-engine initiator, restoring divider, HI/LO registers
module muldiv_ctrl (
    input  logic           clk,
    input  logic           resetn,
    muldiv_ctrl_if.slave   bus
);
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE, S_MUL_ISSUE, S_MUL_WAIT, S_DIV_RUN, S_DONE, S_MUL_DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] hi_q, lo_q;
    logic [32:0] mul_a_q, mul_b_q;
    logic [31:0] quo_q, rem_q, dvsr_q;
    logic [4:0]  cnt_q;
    logic        qsign_q, rsign_q;

    logic        is_mul, is_div, is_mt, is_long, accept, mul_go, div_go;
    logic        stall, mul_en;
    logic [32:0] rem_shift, rem_diff;
    logic        rem_ge;
    logic [31:0] rem_nxt, quo_nxt;
    logic        unused_res_bits;

    assign is_mul  = (bus.req_op == OP_MULT) || (bus.req_op == OP_MULTU);
    assign is_div  = (bus.req_op == OP_DIV)  || (bus.req_op == OP_DIVU);
    assign is_mt   = (bus.req_op == OP_MTHI) || (bus.req_op == OP_MTLO);
    assign is_long = is_mul || is_div;
    assign accept  = (state_q == S_IDLE) && bus.req_valid && !bus.flush;
    // The working guard never fires in normal flow; it keeps a busy engine from a second issue.
    assign mul_go  = accept && is_mul && !bus.mul_working;
    assign div_go  = accept && is_div;

    // One restoring step: shift in the next dividend bit, subtract when it fits.
    assign rem_shift = {rem_q, quo_q[31]};
    assign rem_ge    = rem_shift >= {1'b0, dvsr_q};
    assign rem_diff  = rem_shift - {1'b0, dvsr_q};
    assign rem_nxt   = rem_ge ? rem_diff[31:0] : rem_shift[31:0];
    assign quo_nxt   = {quo_q[30:0], rem_ge};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (mul_go) begin
                    state_d = S_MUL_ISSUE;
                end else if (div_go) begin
                    state_d = S_DIV_RUN;
                end
            end
            S_MUL_ISSUE: state_d = bus.flush ? S_IDLE : S_MUL_WAIT;
            S_MUL_WAIT: begin
                if (bus.mul_finish) begin
                    state_d = bus.flush ? S_IDLE : S_DONE;
                end else if (bus.flush) begin
                    state_d = S_MUL_DRAIN;
                end
            end
            S_DIV_RUN: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 5'd31) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:      state_d = S_IDLE;
            S_MUL_DRAIN: if (bus.mul_finish) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // MTHI/MTLO arriving while not IDLE are held so the write lands once IDLE is reached.
    always_comb begin
        stall  = 1'b0;
        mul_en = 1'b0;
        if (!bus.flush) begin
            case (state_q)
                S_IDLE:      stall = bus.req_valid && is_long;
                S_MUL_ISSUE: begin
                    stall  = 1'b1;
                    mul_en = 1'b1;
                end
                S_MUL_WAIT:  stall = 1'b1;
                S_DIV_RUN:   stall = 1'b1;
                S_DONE:      stall = bus.req_valid && is_mt;
                S_MUL_DRAIN: stall = bus.req_valid && (is_long || is_mt);
                default:     stall = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            hi_q    <= '0;
            lo_q    <= '0;
            mul_a_q <= '0;
            mul_b_q <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvsr_q  <= '0;
            cnt_q   <= '0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
        end else begin
            if (mul_go) begin
                mul_a_q <= {(bus.req_op == OP_MULT) && bus.src_a[31], bus.src_a};
                mul_b_q <= {(bus.req_op == OP_MULT) && bus.src_b[31], bus.src_b};
            end
            if (div_go) begin
                if (bus.req_op == OP_DIV) begin
                    quo_q   <= bus.src_a[31] ? 32'd0 - bus.src_a : bus.src_a;
                    dvsr_q  <= bus.src_b[31] ? 32'd0 - bus.src_b : bus.src_b;
                    qsign_q <= bus.src_a[31] ^ bus.src_b[31];
                    rsign_q <= bus.src_a[31];
                end else begin
                    quo_q   <= bus.src_a;
                    dvsr_q  <= bus.src_b;
                    qsign_q <= 1'b0;
                    rsign_q <= 1'b0;
                end
                rem_q <= '0;
                cnt_q <= '0;
            end
            if (accept && bus.req_op == OP_MTHI) hi_q <= bus.src_a;
            if (accept && bus.req_op == OP_MTLO) lo_q <= bus.src_a;
            if (state_q == S_MUL_WAIT && bus.mul_finish && !bus.flush) begin
                hi_q <= bus.mul_res[63:32];
                lo_q <= bus.mul_res[31:0];
            end
            if (state_q == S_DIV_RUN) begin
                quo_q <= quo_nxt;
                rem_q <= rem_nxt;
                cnt_q <= cnt_q + 5'd1;
                if (cnt_q == 5'd31 && !bus.flush) begin
                    hi_q <= rsign_q ? 32'd0 - rem_nxt : rem_nxt;
                    lo_q <= qsign_q ? 32'd0 - quo_nxt : quo_nxt;
                end
            end
        end
    end

    assign unused_res_bits = ^bus.mul_res[65:64];

    assign bus.stall      = stall;
    assign bus.mul_en     = mul_en;
    assign bus.mul_cancel = 1'b0;
    assign bus.mul_a      = mul_a_q;
    assign bus.mul_b      = mul_b_q;
    assign bus.hi         = hi_q;
    assign bus.lo         = lo_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - bench for muldiv_ctrl with a 3-stage multiplier engine model
module tb_muldiv_ctrl;
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    muldiv_ctrl_if bus();
    muldiv_ctrl dut (.clk(clk), .resetn(resetn), .bus(bus));

    int checks = 0;
    int errors = 0;
    int en_cnt = 0;
    logic [32:0] last_mul_a;
    logic [31:0] hi_m, lo_m;

    // Engine: product appears with mul_finish three cycles after the mul_en cycle.
    logic [2:0]  pv;
    logic [65:0] pd0, pd1, pd2;
    always @(posedge clk) begin
        if (!resetn) begin
            pv <= '0;
        end else begin
            pv  <= {pv[1:0], bus.mul_en};
            pd0 <= $signed(bus.mul_a) * $signed(bus.mul_b);
            pd1 <= pd0;
            pd2 <= pd1;
        end
    end
    assign bus.mul_finish  = pv[2];
    assign bus.mul_working = |pv;
    assign bus.mul_res     = pd2;

    task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (resetn && bus.mul_en) begin
            en_cnt++;
            last_mul_a = bus.mul_a;
            check("en_while_busy", bus.mul_working, 0);
        end
    end

    task automatic ref_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            3'd1: begin p = sa * sb; hi_m = p[63:32]; lo_m = p[31:0]; end
            3'd2: begin p = {32'd0, a} * {32'd0, b}; hi_m = p[63:32]; lo_m = p[31:0]; end
            3'd3: begin
                if (b == 0) begin
                    hi_m = a;
                    lo_m = a[31] ? 32'd1 : 32'hFFFF_FFFF;
                end else begin
                    q = sa / sb; r = sa % sb;
                    hi_m = r[31:0]; lo_m = q[31:0];
                end
            end
            3'd4: begin
                if (b == 0) begin
                    hi_m = a; lo_m = 32'hFFFF_FFFF;
                end else begin
                    hi_m = a % b; lo_m = a / b;
                end
            end
            3'd5: hi_m = a;
            3'd6: lo_m = a;
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int n, en0, exp_stall;
        n = 0;
        en0 = en_cnt;
        exp_stall = (op == 3'd1 || op == 3'd2) ? 5 : (op == 3'd3 || op == 3'd4) ? 33 : 0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = op; bus.src_a = a; bus.src_b = b;
        #1;
        while (bus.stall && n < 100) begin
            @(negedge clk); #1; n++;
        end
        @(negedge clk);
        bus.req_valid = 1'b0; bus.req_op = 3'd0;
        #1;
        ref_apply(op, a, b);
        check($sformatf("stall_cycles op%0d", op), n, exp_stall);
        check($sformatf("hi op%0d %h %h", op, a, b), bus.hi, hi_m);
        check($sformatf("lo op%0d %h %h", op, a, b), bus.lo, lo_m);
        if (op == 3'd1 || op == 3'd2) begin
            check("mul_en_pulses", en_cnt - en0, 1);
            check("mul_a", last_mul_a, {(op == 3'd1) && a[31], a});
        end
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n, en0;
        resetn = 1'b0;
        bus.req_valid = 1'b0; bus.req_op = 3'd0; bus.src_a = '0; bus.src_b = '0; bus.flush = 1'b0;
        hi_m = '0; lo_m = '0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        #1;
        check("rst_stall", bus.stall, 0);
        check("rst_hi", bus.hi, 0);
        check("rst_lo", bus.lo, 0);
        check("rst_mul_en", bus.mul_en, 0);
        check("rst_mul_a", bus.mul_a, 0);
        check("rst_mul_b", bus.mul_b, 0);
        check("mul_cancel", bus.mul_cancel, 0);

        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_hi_const", bus.hi, 32'hFFFF_FFFE);
        check("multu_lo_const", bus.lo, 32'h0000_0001);
        run_op(3'd1, 32'hFFFF_FFFE, 32'd3);
        check("mult_lo_const", bus.lo, 32'hFFFF_FFFA);
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2);
        check("div_lo_const", bus.lo, 32'hFFFF_FFFD);
        check("div_hi_const", bus.hi, 32'hFFFF_FFFF);
        run_op(3'd4, 32'd100, 32'd7);
        check("divu_lo_const", bus.lo, 32'd14);
        check("divu_hi_const", bus.hi, 32'd2);
        run_op(3'd4, 32'd100, 32'd0);
        check("divu0_lo_const", bus.lo, 32'hFFFF_FFFF);
        check("divu0_hi_const", bus.hi, 32'd100);
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'd5, 32'hCAFE_0001, 32'd0);

        // DIV flushed mid-run, then an MTLO goes straight through
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = 3'd3; bus.src_a = 32'd1000; bus.src_b = 32'd3;
        repeat (10) @(negedge clk);
        bus.flush = 1'b1;
        #1;
        check("div_flush_stall", bus.stall, 0);
        @(negedge clk);
        bus.flush = 1'b0; bus.req_op = 3'd6; bus.src_a = 32'h1234;
        #1;
        check("div_flush_hi_kept", bus.hi, hi_m);
        check("div_flush_lo_kept", bus.lo, lo_m);
        check("mtlo_stall", bus.stall, 0);
        @(negedge clk);
        bus.req_valid = 1'b0; bus.req_op = 3'd0;
        #1;
        lo_m = 32'h1234;
        check("mtlo_lo", bus.lo, 32'h1234);
        check("mtlo_hi", bus.hi, hi_m);

        // MULT flushed in MUL_WAIT; the next MULT waits for the stale product to drain
        en0 = en_cnt;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = 3'd1; bus.src_a = 32'd7; bus.src_b = 32'd9;
        repeat (2) @(negedge clk);
        bus.flush = 1'b1;
        #1;
        check("mul_flush_stall", bus.stall, 0);
        @(negedge clk);
        bus.flush = 1'b0; bus.src_a = 32'd5; bus.src_b = 32'd6;
        n = 0;
        #1;
        while (bus.stall && n < 100) begin
            @(negedge clk); #1; n++;
        end
        check("drain_stall_cycles", n, 7);
        @(negedge clk);
        bus.req_valid = 1'b0; bus.req_op = 3'd0;
        #1;
        hi_m = 32'd0; lo_m = 32'd30;
        check("drain_lo", bus.lo, 32'd30);
        check("drain_hi", bus.hi, 32'd0);
        check("drain_en_pulses", en_cnt - en0, 2);

        // reset in the middle of a divide
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = 3'd4; bus.src_a = 32'd77; bus.src_b = 32'd5;
        repeat (5) @(negedge clk);
        resetn = 1'b0; bus.req_valid = 1'b0; bus.req_op = 3'd0;
        @(negedge clk);
        #1;
        hi_m = '0; lo_m = '0;
        check("midrst_hi", bus.hi, 0);
        check("midrst_lo", bus.lo, 0);
        check("midrst_stall", bus.stall, 0);
        check("midrst_mul_en", bus.mul_en, 0);
        resetn = 1'b1;
        run_op(3'd5, 32'h0BAD_F00D, 32'd0);

        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom_range(1, 6)), rnd_val(), rnd_val());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
